// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: writer side of the fabric configuration chains.
// Accepts one bit per chain per beat, shifts it into NUM_CHAINS parallel
// ccff chains and streams the captured ccff_tail back as readback data.
// Everything lives in the prog_clk domain.
module ccff_bitstream_loader #(
  parameter int NUM_CHAINS = 8,
  parameter int CHAIN_LEN  = 1024,
  parameter int CNT_W      = $clog2(CHAIN_LEN + 1)
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [NUM_CHAINS-1:0] s_data,
  input  logic                  s_last,
  output logic [NUM_CHAINS-1:0] ccff_head,
  output logic                  ccff_shift_en,
  input  logic [NUM_CHAINS-1:0] ccff_tail,
  output logic                  config_enable,
  output logic                  rb_valid,
  output logic [NUM_CHAINS-1:0] rb_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CNT_W-1:0]      beat_cnt
);

  // Accepted-beat valid travels one stage to become shift_en, one more to
  // become rb_valid.
  localparam int STAGES = 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_DONE,
    S_ERR
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [STAGES:0]         vld_pipe;
  logic [NUM_CHAINS-1:0]   head_q, rb_q;
  logic                    beat_ok;
  logic                    accept;
  logic                    is_final;

  // State and beat counter registers.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: framing checks on each accepted beat, abort priority.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    beat_ok  = 1'b0;
    s_ready  = (state_q == S_LOAD) && !abort;
    accept   = s_valid && s_ready;
    is_final = (cnt_q == CNT_LAST);
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start && abort) begin
          state_d = S_IDLE;
        end else if (start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (accept) begin
          // s_last must appear on exactly the final beat; a mismatch is
          // dropped without a shift.
          if (s_last != is_final) begin
            state_d = S_ERR;
          end else begin
            beat_ok = 1'b1;
            cnt_d   = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + 1'b1;
            if (is_final) state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: state_d = abort ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Valid pipe: [0] = shift issued this cycle, [1] = readback beat.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) vld_pipe <= '0;
    else            vld_pipe <= {vld_pipe[STAGES-1:0], beat_ok};
  end

  // Chain head data and readback capture; both hold when idle.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      head_q <= '0;
      rb_q   <= '0;
    end else begin
      if (beat_ok)     head_q <= s_data;
      if (vld_pipe[0]) rb_q   <= ccff_tail;
    end
  end

  assign ccff_head     = head_q;
  assign ccff_shift_en = vld_pipe[0];
  assign rb_valid      = vld_pipe[STAGES];
  assign rb_data       = rb_q;
  assign config_enable = (state_q == S_LOAD) || (state_q == S_FLUSH);
  assign busy          = config_enable;
  assign done          = (state_q == S_DONE);
  assign err           = (state_q == S_ERR);
  assign beat_cnt      = cnt_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader with CHAIN_LEN=4, 8 chains, and a
// word-wide model of the fabric chains driving ccff_tail.
module tb_ccff_bitstream_loader;
  localparam int NC = 8;
  localparam int CL = 4;
  localparam int CW = $clog2(CL + 1);

  logic          clk = 1'b0;
  logic          prog_reset, start, abort, s_valid, s_last;
  logic [NC-1:0] s_data;
  logic          s_ready, ccff_shift_en, config_enable, rb_valid;
  logic          busy, done, err;
  logic [NC-1:0] ccff_head, ccff_tail, rb_data;
  logic [CW-1:0] beat_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  ccff_bitstream_loader #(.NUM_CHAINS(NC), .CHAIN_LEN(CL)) dut (
    .prog_clk(clk), .prog_reset(prog_reset), .start(start), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
    .config_enable(config_enable), .rb_valid(rb_valid), .rb_data(rb_data),
    .busy(busy), .done(done), .err(err), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  // Fabric chain model: chain[0] nearest the head, chain[CL-1] drives tail.
  logic [NC-1:0] chain [CL] = '{default: '0};
  assign ccff_tail = chain[CL-1];
  always @(posedge clk) begin
    if (ccff_shift_en) begin
      for (int i = CL - 1; i > 0; i--) chain[i] <= chain[i-1];
      chain[0] <= ccff_head;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor for the hand-written load sequences.
  bit mon_on = 1'b0;
  int acc_q[$], rbc_q[$];
  logic [NC-1:0] sh_q[$], rb_q[$];
  always @(negedge clk) begin
    if (mon_on) begin
      if (s_valid && s_ready) acc_q.push_back(cyc);
      if (ccff_shift_en) sh_q.push_back(ccff_head);
      if (rb_valid) begin
        rb_q.push_back(rb_data);
        rbc_q.push_back(cyc);
      end
    end
  end

  task automatic chk(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  // Per-cycle vector: inputs for the cycle and outputs expected during it.
  typedef struct {
    logic st, ab, rs, sv;
    logic [7:0] sd;
    logic sl;
    logic busy, done, err, cfg, rdy, sh;
    logic [7:0] head;
    int cnt;            // -1: not checked
    logic rbv;
    logic [7:0] rb;
  } vec_t;

  vec_t vecs[$];

  task automatic run_load(input logic [3:0][7:0] d, input bit stall,
                          input bit chk_rb, input logic [3:0][7:0] exp_rb,
                          input string tag);
    int k, g;
    bit taken;
    acc_q.delete(); sh_q.delete(); rb_q.delete(); rbc_q.delete();
    mon_on = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; g = 0;
    while (k < 4 && g < 40) begin
      if (stall && g[0]) begin
        s_valid = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_data  = d[k];
        s_last  = (k == 3);
      end
      @(negedge clk);
      taken = s_valid && s_ready;
      @(posedge clk); #1;
      if (taken) k++;
      g++;
    end
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    chk({tag, " beats_taken"}, 0, 16'(k), 16'd4);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk({tag, " done"}, 0, 16'(done), 16'd1);
    chk({tag, " cfg_en_in_done"}, 0, 16'(config_enable), 16'd0);
    mon_on = 1'b0;
    chk({tag, " accepts"}, 0, 16'(acc_q.size()), 16'd4);
    chk({tag, " shift_pulses"}, 0, 16'(sh_q.size()), 16'd4);
    chk({tag, " rb_beats"}, 0, 16'(rb_q.size()), 16'd4);
    for (int j = 0; j < 4; j++) begin
      if (j < sh_q.size()) chk({tag, " head_order"}, j, 16'(sh_q[j]), 16'(d[j]));
      if (chk_rb && j < rb_q.size()) chk({tag, " rb_data"}, j, 16'(rb_q[j]), 16'(exp_rb[j]));
      if (j < rbc_q.size() && j < acc_q.size())
        chk({tag, " rb_latency"}, j, 16'(rbc_q[j] - acc_q[j]), 16'd2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0][7:0] pa, pb, none;
    //                  st ab rs sv sd    sl  busy done err cfg rdy sh head  cnt rbv rb
    // Test 1: clean load 01,02,04,88
    vecs.push_back(vec_t'{1,0,0,0,8'h00,0, 0,0,0,0,0,0,8'h00, 0,0,8'h00}); // c0 IDLE
    vecs.push_back(vec_t'{0,0,0,1,8'h01,0, 1,0,0,1,1,0,8'h00, 0,0,8'h00});
    vecs.push_back(vec_t'{0,0,0,1,8'h02,0, 1,0,0,1,1,1,8'h01, 1,0,8'h00});
    vecs.push_back(vec_t'{0,0,0,1,8'h04,0, 1,0,0,1,1,1,8'h02, 2,1,8'h00});
    vecs.push_back(vec_t'{0,0,0,1,8'h88,1, 1,0,0,1,1,1,8'h04, 3,1,8'h00});
    vecs.push_back(vec_t'{0,0,0,0,8'h00,0, 1,0,0,1,0,1,8'h88, 4,1,8'h00}); // FLUSH
    vecs.push_back(vec_t'{0,0,0,0,8'h00,0, 0,1,0,0,0,0,8'h88, 4,1,8'h00}); // DONE
    vecs.push_back(vec_t'{0,0,0,0,8'h00,0, 0,1,0,0,0,0,8'h88, 4,0,8'h00});
    // Test 4: early s_last on beat 2
    vecs.push_back(vec_t'{1,0,0,0,8'h00,0, 0,1,0,0,0,0,8'h88, 4,0,8'h00});
    vecs.push_back(vec_t'{0,0,0,1,8'h11,0, 1,0,0,1,1,0,8'h88, 0,0,8'h00});
    vecs.push_back(vec_t'{0,0,0,1,8'h22,1, 1,0,0,1,1,1,8'h11, 1,0,8'h00});
    vecs.push_back(vec_t'{0,0,0,0,8'h00,0, 0,0,1,0,0,0,8'h11,-1,1,8'h01}); // ERR
    vecs.push_back(vec_t'{1,0,0,0,8'h00,0, 0,0,1,0,0,0,8'h11,-1,0,8'h01});
    // Test 5: missing s_last on beat 4
    vecs.push_back(vec_t'{0,0,0,1,8'hA1,0, 1,0,0,1,1,0,8'h11, 0,0,8'h01});
    vecs.push_back(vec_t'{0,0,0,1,8'hA2,0, 1,0,0,1,1,1,8'hA1, 1,0,8'h01});
    vecs.push_back(vec_t'{0,0,0,1,8'hA3,0, 1,0,0,1,1,1,8'hA2, 2,1,8'h02});
    vecs.push_back(vec_t'{0,0,0,1,8'hA4,0, 1,0,0,1,1,1,8'hA3, 3,1,8'h04});
    vecs.push_back(vec_t'{0,0,0,0,8'h00,0, 0,0,1,0,0,0,8'hA3,-1,1,8'h88}); // ERR
    vecs.push_back(vec_t'{0,0,0,0,8'h00,0, 0,0,1,0,0,0,8'hA3,-1,0,8'h88});
    // Test 6: abort after beat 2, abort beats a same-cycle beat
    vecs.push_back(vec_t'{1,0,0,0,8'h00,0, 0,0,1,0,0,0,8'hA3,-1,0,8'h88});
    vecs.push_back(vec_t'{0,0,0,1,8'hB1,0, 1,0,0,1,1,0,8'hA3, 0,0,8'h88});
    vecs.push_back(vec_t'{0,0,0,1,8'hB2,0, 1,0,0,1,1,1,8'hB1, 1,0,8'h88});
    vecs.push_back(vec_t'{0,1,0,1,8'hB3,0, 1,0,0,1,0,1,8'hB2, 2,1,8'h11});
    vecs.push_back(vec_t'{0,0,0,0,8'h00,0, 0,0,0,0,0,0,8'hB2, 2,1,8'hA1}); // IDLE
    // Same with prog_reset mid-load
    vecs.push_back(vec_t'{1,0,0,0,8'h00,0, 0,0,0,0,0,0,8'hB2, 2,0,8'hA1});
    vecs.push_back(vec_t'{0,0,0,1,8'hC1,0, 1,0,0,1,1,0,8'hB2, 0,0,8'hA1});
    vecs.push_back(vec_t'{0,0,0,1,8'hC2,0, 1,0,0,1,1,1,8'hC1, 1,0,8'hA1});
    vecs.push_back(vec_t'{0,0,1,1,8'hC3,0, 1,0,0,1,1,1,8'hC2, 2,1,8'hA2});
    vecs.push_back(vec_t'{0,0,0,0,8'h00,0, 0,0,0,0,0,0,8'h00, 0,0,8'h00}); // after reset

    start = 0; abort = 0; s_valid = 0; s_last = 0; s_data = '0;
    prog_reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 0,
        16'({ccff_head, ccff_shift_en, config_enable, rb_valid, rb_data}), 16'd0);
    chk("reset_status", 0, 16'({beat_cnt, s_ready, busy, done, err}), 16'd0);
    @(posedge clk); #1;
    prog_reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].st; abort = vecs[i].ab; prog_reset = vecs[i].rs;
      s_valid = vecs[i].sv; s_data = vecs[i].sd; s_last = vecs[i].sl;
      @(negedge clk);
      chk("busy", i, 16'(busy), 16'(vecs[i].busy));
      chk("done", i, 16'(done), 16'(vecs[i].done));
      chk("err", i, 16'(err), 16'(vecs[i].err));
      chk("config_enable", i, 16'(config_enable), 16'(vecs[i].cfg));
      chk("s_ready", i, 16'(s_ready), 16'(vecs[i].rdy));
      chk("shift_en", i, 16'(ccff_shift_en), 16'(vecs[i].sh));
      chk("ccff_head", i, 16'(ccff_head), 16'(vecs[i].head));
      if (vecs[i].cnt >= 0) chk("beat_cnt", i, 16'(beat_cnt), 16'(vecs[i].cnt));
      chk("rb_valid", i, 16'(rb_valid), 16'(vecs[i].rbv));
      chk("rb_data", i, 16'(rb_data), 16'(vecs[i].rb));
      @(posedge clk); #1;
    end
    start = 0; abort = 0; prog_reset = 0; s_valid = 0; s_last = 0; s_data = '0;

    // Test 2: stalled source, also fills the chains with A5,5A,FF,00.
    pa[0] = 8'hA5; pa[1] = 8'h5A; pa[2] = 8'hFF; pa[3] = 8'h00;
    none = '0;
    run_load(pa, 1'b1, 1'b0, none, "stall_load");
    // Test 3: reload reads back the previous contents in order.
    pb[0] = 8'h11; pb[1] = 8'h22; pb[2] = 8'h33; pb[3] = 8'h44;
    run_load(pb, 1'b0, 1'b1, pa, "readback_load");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
